if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction-fetch stage of the MIPS pipeline: owns the PC, issues single-outstanding requests on the SRAM-like instruction port in front of the AXI bridge, and holds the returned word in a one-entry buffer. It drives the data and clear inputs of the IF/ID pipeline register directly downstream. It inserts bubbles while fetch is pending and discards in-flight fetches on a branch or exception redirect.

## Interface
- RESET_PC, 32'hBFC0_0000, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall_i  in  1  ID stage stalled; IF/ID must hold
- redirect_i  in  1  one-cycle pulse: branch taken / exception / eret
- redirect_pc_i  in  32  target PC, sampled when redirect_i=1
- inst_req  out  1  fetch request valid
- inst_addr  out  32  fetch address (= pc)
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  32  read data
- if_pc_o  out  32  PC of buffered instruction
- if_inst_o  out  32  buffered instruction
- if_adel_o  out  1  buffered entry is a misaligned-fetch fault
- if_valid_o  out  1  buffer holds a valid entry
- ifid_clear_o  out  1  clear input of IF/ID register

## Operation
- State: pc[31:0], FSM {REQ, WAIT, DISCARD}, buffer {valid, pc, inst, adel}.
- free = !buf_valid | !stall_i. This is combinational: the buffer is empty, or it is consumed this cycle.
- REQ:
  - inst_req = free & !redirect_i & (pc[1:0]==0).
  - On inst_req & inst_addr_ok, go to WAIT. The pc stays put until data returns.
  - If pc[1:0]!=0 and free, write the buffer with {valid=1, pc, inst=0, adel=1} without a bus request, then pc<=pc+4. The core redirects on the exception.
- WAIT:
  - On inst_data_ok, buffer <= {1, pc, inst_rdata, 0}, pc <= pc+4, go to REQ.
- DISCARD:
  - On inst_data_ok, drop the data and go to REQ. The pc already holds the redirect target.
- Redirect (redirect_i=1, highest priority):
  - pc <= redirect_pc_i and buf_valid <= 0.
  - In REQ, stay in REQ. inst_req is masked that cycle, so no stale address is accepted.
  - In WAIT without inst_data_ok, go to DISCARD.
  - In WAIT with inst_data_ok the same cycle, drop the data and go to REQ.
  - In DISCARD with inst_data_ok the same cycle, go to REQ. Otherwise stay in DISCARD.
- Buffer consume: when buf_valid & !stall_i and no new write this cycle, buf_valid <= 0.
- Buffer write: happens only on data return or fault entry. Because only one request is outstanding and requests are gated by free, a write never overwrites an unconsumed entry.
- ifid_clear_o = !stall_i & (redirect_i | !buf_valid).
- if_pc_o, if_inst_o and if_adel_o drive the IF/ID d input. They hold their value while buf_valid=0.
- PC arithmetic is modulo 2^32. pc+4 from 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values:
  - pc = RESET_PC, FSM = REQ, buf_valid = 0.
  - if_pc_o = 0, if_inst_o = 0, if_adel_o = 0, if_valid_o = 0.
  - inst_req = 0 while rst is high. inst_addr = RESET_PC.
  - ifid_clear_o = 1 after reset, with stall_i=0.
- Minimum latency:
  - addr_ok at cycle t.
  - data_ok at cycle t+1.
  - if_valid_o=1 from t+2, the same edge at which pc advances.
- Peak throughput: one instruction per 2 cycles.
- inst_addr is stable while inst_req=1 and addr_ok=0, except on a redirect cycle, where inst_req is forced low.
- Reset mid-transaction returns the FSM to REQ and abandons any outstanding beat. The bridge is reset by the same rst.
- If stall_i persists while buf_valid=1, inst_req stays 0 and the buffer holds its value.

## Test plan
- Reset, then zero-wait memory (addr_ok in the req cycle, data_ok on the next cycle): fetches from BFC00000, BFC00004, BFC00008. if_valid_o rises 2 cycles after the first addr_ok. ifid_clear_o is 1 on the bubble cycles.
- stall_i=1 for 5 cycles with buffer valid at pc BFC00004: inst_req stays 0, if_inst_o is held, ifid_clear_o=0. Fetch of BFC00008 is issued the cycle stall_i drops.
- redirect_i to 80000180 while in WAIT, with data_ok arriving 3 cycles later: the returned word is discarded, the next request address is 80000180, and ifid_clear_o=1 in the redirect cycle.
- redirect_i in the same cycle as inst_data_ok: the data is dropped, the next request goes to the target, and if_valid_o stays 0.
- Redirect to 80000002: no bus request is issued. The buffer shows adel=1, pc=80000002, inst=0.
- Assert rst while in WAIT: all outputs return to reset values immediately. After release, the first request goes to BFC00000.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: SRAM-like instruction port between the fetch stage and the AXI bridge.
interface if_fetch_unit_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  modport master (output inst_req, inst_addr, input inst_addr_ok, inst_data_ok, inst_rdata);
  modport slave  (input inst_req, inst_addr, output inst_addr_ok, inst_data_ok, inst_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS IF stage; single-outstanding fetch with a one-entry buffer feeding IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [31:0]           redirect_pc_i,
  if_fetch_unit_if.master       bus,
  output logic [31:0]           if_pc_o,
  output logic [31:0]           if_inst_o,
  output logic                  if_adel_o,
  output logic                  if_valid_o,
  output logic                  ifid_clear_o
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, buf_pc_q, buf_inst_q;
  logic        buf_valid_q, buf_valid_d, buf_adel_q;
  logic        free, aligned, fault, data_wr, buf_wr;
  assign free    = !buf_valid_q | !stall_i;
  assign aligned = pc_q[1:0] == 2'b00;
  assign fault   = state_q == S_REQ & free & !redirect_i & !aligned;
  assign data_wr = state_q == S_WAIT & bus.inst_data_ok & !redirect_i;
  assign buf_wr  = data_wr | fault;
  assign bus.inst_req  = !rst & state_q == S_REQ & free & !redirect_i & aligned;
  assign bus.inst_addr = pc_q;
  assign if_pc_o      = buf_pc_q;
  assign if_inst_o    = buf_inst_q;
  assign if_adel_o    = buf_adel_q;
  assign if_valid_o   = buf_valid_q;
  assign ifid_clear_o = !stall_i & (redirect_i | !buf_valid_q);
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:     state_d = (bus.inst_req & bus.inst_addr_ok) ? S_WAIT : S_REQ;
      S_WAIT:    state_d = bus.inst_data_ok ? S_REQ : (redirect_i ? S_DISCARD : S_WAIT);
      S_DISCARD: state_d = bus.inst_data_ok ? S_REQ : S_DISCARD;
      default:   state_d = S_REQ;
    endcase
    pc_d        = redirect_i ? redirect_pc_i : (buf_wr ? pc_q + 32'd4 : pc_q);
    buf_valid_d = redirect_i ? 1'b0 : (buf_wr | (buf_valid_q & stall_i));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= '0;
      buf_inst_q  <= '0;
      buf_adel_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_valid_q <= buf_valid_d;
      if (buf_wr) begin
        buf_pc_q   <= pc_q;
        buf_inst_q <= fault ? 32'd0 : bus.inst_rdata;
        buf_adel_q <= fault;
      end
    end
  end
endmodule
